rob_alloc_ctrl: RTL and testbench
=================================

Name: rob_alloc_ctrl

Overview:
- Parametrised ROB allocation controller between rename (stage4) and dispatch.
- Owns the ROB write/read pointers and their wrap bits, and computes occupancy and room.
- Assigns compacted ROB IDs to up to DISPATCH_W instructions per cycle and masks IQ dispatch for lanes younger than an excepting lane.
- Generates the dispatch pause, including a post-flush recovery bubble, and keeps a saturating stall counter.

Parameters:
- DISPATCH_W, 4, instructions presented per cycle (1..8).
- RETIRE_W, 4, maximum entries retired per cycle.
- ROB_DEPTH, 64, ROB entries; must be a power of 2.
- ID_W, $clog2(ROB_DEPTH), ROB ID width.
- FLUSH_BUBBLE, 1, cycles wr_pause stays high after flush (0 = none).
- STALL_CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; empties ROB.
- inst_vld  in  DISPATCH_W  lane valid, lane 0 oldest.
- inst_except  in  DISPATCH_W  lane carries front-end exception (OR of its exception code).
- iq_pause  in  1  OR of all IQ write-pause requests.
- retire_num  in  $clog2(RETIRE_W+1)  entries committed this cycle.
- inst_rob_id  out  DISPATCH_W*ID_W  per-lane ROB ID, lane i at [i*ID_W +: ID_W].
- inst_iq_en  out  DISPATCH_W  lane may be written to an IQ.
- alloc_num  out  $clog2(DISPATCH_W+1)  ROB entries requested.
- alloc_fire  out  1  allocation accepted this cycle.
- wr_pause  out  1  stall rename/dispatch.
- wr_ptr_exp  out  ID_W+1  write pointer with wrap bit.
- rd_ptr_exp  out  ID_W+1  read pointer with wrap bit.
- rob_room  out  ID_W+1  free entries.
- rob_empty, rob_full  out  1 each  occupancy == 0 / == ROB_DEPTH.
- stall_cnt  out  STALL_CNT_W  cycles with wr_pause=1 and alloc_num>0.

Behaviour:
- occ_i = inst_vld[i] | inst_except[i]. alloc_num = popcount(occ).
- inst_rob_id[i] = wr_ptr[ID_W-1:0] + popcount(occ[i-1:0]), mod ROB_DEPTH. Lanes with occ_i=0 output the ID the next occupying lane would get. The IDs are combinational.
- inst_iq_en[i] = inst_vld[i] & ~|inst_except[i-1:0] & ~wr_pause. The lane's own exception does not mask it.
- occupancy = wr_ptr_exp - rd_ptr_exp, computed at ID_W+1 bits. rob_room = ROB_DEPTH - occupancy.
- wr_pause = iq_pause | (alloc_num > rob_room) | flush | (bub_cnt != 0).
- The room check uses the current-cycle room only. A same-cycle retire does not count, so the check is conservative.
- alloc_fire = (alloc_num != 0) & ~wr_pause.
- Sequential update, when not flushing:
  - rd_ptr_exp += retire_num.
  - If alloc_fire, wr_ptr_exp += alloc_num.
  - Both additions wrap naturally at ID_W+1 bits; the wrap bit toggles on crossing ROB_DEPTH.
- Flush has priority over allocation:
  - rd_ptr_exp <= rd_ptr_exp + retire_num and wr_ptr_exp <= the same value, so the ROB is empty next cycle.
  - bub_cnt <= FLUSH_BUBBLE.
- Recovery state machine:
  - IDLE: bub_cnt == 0.
  - RECOVER: bub_cnt != 0. bub_cnt decrements each cycle and returns to IDLE at 0.
  - A flush during RECOVER reloads bub_cnt to FLUSH_BUBBLE.
- stall_cnt increments when wr_pause & (alloc_num != 0). It saturates at all-ones. Flush does not clear it.
- Reset (asynchronous, any time, including mid-RECOVER) sets:
  - wr_ptr_exp = 0, rd_ptr_exp = 0, bub_cnt = 0, stall_cnt = 0.
  - Hence rob_room = ROB_DEPTH, rob_empty = 1, rob_full = 0, wr_pause = iq_pause.
- Error condition: retire_num > occupancy is illegal. The bench asserts on it; the RTL behaviour is undefined.

Decomposition:
- Shared package rob_pkg: ROB_DEPTH, ID_W, rob_id_t, rob_ptr_t (ID_W+1 bits), DISPATCH_W, RETIRE_W.
- One sub-module, prefix_popcount: DISPATCH_W-bit exclusive prefix counts plus total. It is reused by IQ slot allocation.

Test Plan:
- Reset: release rst_n -> wr_ptr_exp=0, rob_room=64, rob_empty=1, wr_pause=0, stall_cnt=0.
- Wrap: wr_ptr_exp=62, inst_vld=4'b1011, no exceptions ->
  - IDs lane0=62, lane1=63, lane2=0, lane3=0; alloc_num=3, alloc_fire=1.
  - Next cycle wr_ptr_exp=7'h41, rob_room=61.
- Exception mask: wr_ptr=5, inst_vld=4'b0110, inst_except=4'b0001 ->
  - alloc_num=3, IDs lane0=5, lane1=6, lane2=7; inst_iq_en=4'b0000.
- Room stall: rob_room=2, alloc_num=3, retire_num=2 ->
  - wr_pause=1, wr_ptr unchanged, stall_cnt+1.
  - Next cycle rob_room=4, alloc_fire=1.
- Flush: occupancy 10, retire_num=1 with flush, FLUSH_BUBBLE=2 ->
  - Next cycle wr_ptr_exp==rd_ptr_exp (old rd+1), rob_empty=1.
  - wr_pause high exactly 3 cycles (flush cycle + 2), alloc_fire=0 throughout.
- Reset mid-RECOVER: assert rst_n=0 with bub_cnt=1 -> immediately bub_cnt=0, ptrs=0; after release wr_pause follows iq_pause only.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB sizing, pointer types and recovery states.
// Imported by the ROB allocation controller and its helpers.
package rob_pkg;

  localparam int DISPATCH_W = 4;
  localparam int RETIRE_W   = 4;
  localparam int ROB_DEPTH  = 64;
  localparam int ID_W       = $clog2(ROB_DEPTH);

  typedef logic [ID_W-1:0] rob_id_t;
  typedef logic [ID_W:0]   rob_ptr_t;

  typedef enum logic {
    RCV_IDLE,
    RCV_BUBBLE
  } rcv_state_e;

endpackage

// File: rtl/prefix_popcount.sv
// Exclusive prefix popcount of a W-bit mask plus its total.
// Ports: in_mask (W), prefix (lane i at [i*CW +: CW]), total (CW).
module prefix_popcount #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]    in_mask,
  output logic [W*CW-1:0] prefix,
  output logic [CW-1:0]   total
);

  logic [CW-1:0] acc;

  always_comb begin
    prefix = '0;
    acc    = '0;
    for (int i = 0; i < W; i++) begin
      prefix[i*CW +: CW] = acc;
      acc = acc + CW'(in_mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: pointers, room, compacted IDs, pause.
// Ports: flush/vld/except/iq_pause/retire in; ids, iq_en, ptrs, room out.
module rob_alloc_ctrl #(
  parameter int DISPATCH_W   = rob_pkg::DISPATCH_W,
  parameter int RETIRE_W     = rob_pkg::RETIRE_W,
  parameter int ROB_DEPTH    = rob_pkg::ROB_DEPTH,
  parameter int ID_W         = $clog2(ROB_DEPTH),
  parameter int FLUSH_BUBBLE = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [DISPATCH_W-1:0]            inst_vld,
  input  logic [DISPATCH_W-1:0]            inst_except,
  input  logic                             iq_pause,
  input  logic [$clog2(RETIRE_W+1)-1:0]    retire_num,
  output logic [DISPATCH_W*ID_W-1:0]       inst_rob_id,
  output logic [DISPATCH_W-1:0]            inst_iq_en,
  output logic [$clog2(DISPATCH_W+1)-1:0]  alloc_num,
  output logic                             alloc_fire,
  output logic                             wr_pause,
  output logic [ID_W:0]                    wr_ptr_exp,
  output logic [ID_W:0]                    rd_ptr_exp,
  output logic [ID_W:0]                    rob_room,
  output logic                             rob_empty,
  output logic                             rob_full,
  output logic [STALL_CNT_W-1:0]           stall_cnt
);

  import rob_pkg::*;

  localparam int AW = $clog2(DISPATCH_W + 1);
  localparam int BW =
    (FLUSH_BUBBLE > 0) ? $clog2(FLUSH_BUBBLE + 1) : 1;
  localparam logic [ID_W:0] DEPTH = (ID_W+1)'(ROB_DEPTH);
  localparam logic [BW-1:0] BUB_LOAD = BW'(FLUSH_BUBBLE);

  logic [ID_W:0] wr_ptr_q, wr_ptr_d;
  logic [ID_W:0] rd_ptr_q, rd_ptr_d;
  logic [ID_W:0] rd_adv;
  logic [ID_W:0] occupancy;
  logic [BW-1:0] bub_cnt_q, bub_cnt_d;
  rcv_state_e    state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [DISPATCH_W-1:0]    occ;
  logic [DISPATCH_W*AW-1:0] lane_pre;
  logic                     exc_seen;

  assign occ = inst_vld | inst_except;

  prefix_popcount #(
    .W  (DISPATCH_W),
    .CW (AW)
  ) u_occ_cnt (
    .in_mask (occ),
    .prefix  (lane_pre),
    .total   (alloc_num)
  );

  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign rob_room  = DEPTH - occupancy;
  assign rob_empty = (occupancy == '0);
  assign rob_full  = (occupancy == DEPTH);

  // Room check ignores same-cycle retire: conservative by design.
  assign wr_pause = iq_pause
                  | ((ID_W+1)'(alloc_num) > rob_room)
                  | flush
                  | (bub_cnt_q != '0);

  assign alloc_fire = (alloc_num != '0) & ~wr_pause;

  // Idle lanes report the ID the next occupying lane would take.
  always_comb begin
    inst_rob_id = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      inst_rob_id[i*ID_W +: ID_W] =
        wr_ptr_q[ID_W-1:0] + ID_W'(lane_pre[i*AW +: AW]);
    end
  end

  // Lanes younger than an excepting lane never reach an IQ.
  always_comb begin
    inst_iq_en = '0;
    exc_seen   = 1'b0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      inst_iq_en[i] = inst_vld[i] & ~exc_seen & ~wr_pause;
      exc_seen      = exc_seen | inst_except[i];
    end
  end

  always_comb begin
    rd_adv   = rd_ptr_q + (ID_W+1)'(retire_num);
    rd_ptr_d = rd_adv;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      wr_ptr_d = rd_adv;
    end else if (alloc_fire) begin
      wr_ptr_d = wr_ptr_q + (ID_W+1)'(alloc_num);
    end
  end

  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    unique case (state_q)
      RCV_IDLE: begin
        if (flush && (FLUSH_BUBBLE != 0)) begin
          bub_cnt_d = BUB_LOAD;
          state_d   = RCV_BUBBLE;
        end
      end
      RCV_BUBBLE: begin
        if (flush) begin
          bub_cnt_d = BUB_LOAD;
        end else begin
          bub_cnt_d = bub_cnt_q - BW'(1);
          if (bub_cnt_d == '0) state_d = RCV_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (wr_pause && (alloc_num != '0) && !(&stall_q)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      bub_cnt_q <= '0;
      state_q   <= RCV_IDLE;
      stall_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      bub_cnt_q <= bub_cnt_d;
      state_q   <= state_d;
      stall_q   <= stall_d;
    end
  end

  assign wr_ptr_exp = wr_ptr_q;
  assign rd_ptr_exp = rd_ptr_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl (64 entries, 4 lanes, bubble 2).
// Hand-computed pointer, ID, pause and counter expectations.
module tb_rob_alloc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        iq_pause = 1'b0;
  logic [3:0]  inst_vld = '0;
  logic [3:0]  inst_except = '0;
  logic [2:0]  retire_num = '0;
  logic [23:0] inst_rob_id;
  logic [3:0]  inst_iq_en;
  logic [2:0]  alloc_num;
  logic        alloc_fire;
  logic        wr_pause;
  logic [6:0]  wr_ptr_exp;
  logic [6:0]  rd_ptr_exp;
  logic [6:0]  rob_room;
  logic        rob_empty;
  logic        rob_full;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  rob_alloc_ctrl #(
    .DISPATCH_W   (4),
    .RETIRE_W     (4),
    .ROB_DEPTH    (64),
    .ID_W         (6),
    .FLUSH_BUBBLE (2),
    .STALL_CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .inst_vld    (inst_vld),
    .inst_except (inst_except),
    .iq_pause    (iq_pause),
    .retire_num  (retire_num),
    .inst_rob_id (inst_rob_id),
    .inst_iq_en  (inst_iq_en),
    .alloc_num   (alloc_num),
    .alloc_fire  (alloc_fire),
    .wr_pause    (wr_pause),
    .wr_ptr_exp  (wr_ptr_exp),
    .rd_ptr_exp  (rd_ptr_exp),
    .rob_room    (rob_room),
    .rob_empty   (rob_empty),
    .rob_full    (rob_full),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus legality: never retire more than is occupied.
  always @(posedge clk) begin
    if (rst_n && ({4'b0, retire_num} > 7'(wr_ptr_exp - rd_ptr_exp))) begin
      n_fail++;
      $display("FAIL retire_legal: retire=%0d occ=%0d",
               retire_num, 7'(wr_ptr_exp - rd_ptr_exp));
    end
  end

  function automatic logic [5:0] lane_id(input int i);
    return inst_rob_id[i*6 +: 6];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] e,
                       input logic [2:0] r, input logic fl,
                       input logic iq);
    inst_vld = v;
    inst_except = e;
    retire_num = r;
    flush = fl;
    iq_pause = iq;
    #1;
  endtask

  task automatic test_reset;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++; if (wr_ptr_exp !== 7'd0) begin n_fail++;
      $display("FAIL rst_wr: got %0d want 0", wr_ptr_exp); end
    n_chk++; if (rd_ptr_exp !== 7'd0) begin n_fail++;
      $display("FAIL rst_rd: got %0d want 0", rd_ptr_exp); end
    n_chk++; if (rob_room !== 7'd64) begin n_fail++;
      $display("FAIL rst_room: got %0d want 64", rob_room); end
    n_chk++; if (rob_empty !== 1'b1 || rob_full !== 1'b0) begin n_fail++;
      $display("FAIL rst_flags: got e=%b f=%b want e=1 f=0",
               rob_empty, rob_full); end
    n_chk++; if (wr_pause !== 1'b0) begin n_fail++;
      $display("FAIL rst_pause: got %b want 0", wr_pause); end
    n_chk++; if (stall_cnt !== 16'd0) begin n_fail++;
      $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_wrap;
    drive(4'b1111, 4'b0, 3'd0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 14; k++) begin
      drive(4'b1111, 4'b0, 3'd4, 1'b0, 1'b0);
      tick();
    end
    drive(4'b0011, 4'b0, 3'd4, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 4'b0, 3'd2, 1'b0, 1'b0);
    tick();
    drive(4'b1011, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++; if (wr_ptr_exp !== 7'd62 || rob_empty !== 1'b1) begin n_fail++;
      $display("FAIL wrap_pre: got wr=%0d e=%b want 62 1",
               wr_ptr_exp, rob_empty); end
    n_chk++;
    if (lane_id(0) !== 6'd62 || lane_id(1) !== 6'd63 ||
        lane_id(2) !== 6'd0 || lane_id(3) !== 6'd0) begin n_fail++;
      $display("FAIL wrap_ids: got %0d %0d %0d %0d want 62 63 0 0",
               lane_id(0), lane_id(1), lane_id(2), lane_id(3)); end
    n_chk++; if (alloc_num !== 3'd3 || alloc_fire !== 1'b1) begin n_fail++;
      $display("FAIL wrap_alloc: got n=%0d f=%b want 3 1",
               alloc_num, alloc_fire); end
    n_chk++; if (inst_iq_en !== 4'b1011) begin n_fail++;
      $display("FAIL wrap_iq_en: got %b want 1011", inst_iq_en); end
    tick();
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++; if (wr_ptr_exp !== 7'h41 || rob_room !== 7'd61) begin n_fail++;
      $display("FAIL wrap_post: got wr=%h room=%0d want 41 61",
               wr_ptr_exp, rob_room); end
  endtask

  task automatic test_except_mask;
    drive(4'b1111, 4'b0, 3'd3, 1'b0, 1'b0);
    tick();
    drive(4'b0110, 4'b0001, 3'd0, 1'b0, 1'b0);
    n_chk++; if (alloc_num !== 3'd3) begin n_fail++;
      $display("FAIL exc_alloc: got %0d want 3", alloc_num); end
    n_chk++;
    if (lane_id(0) !== 6'd5 || lane_id(1) !== 6'd6 ||
        lane_id(2) !== 6'd7) begin n_fail++;
      $display("FAIL exc_ids: got %0d %0d %0d want 5 6 7",
               lane_id(0), lane_id(1), lane_id(2)); end
    n_chk++; if (inst_iq_en !== 4'b0000) begin n_fail++;
      $display("FAIL exc_iq_en: got %b want 0000", inst_iq_en); end
    tick();
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++; if (wr_ptr_exp !== 7'h48) begin n_fail++;
      $display("FAIL exc_wr: got %h want 48", wr_ptr_exp); end
    drive(4'b1010, 4'b0100, 3'd0, 1'b0, 1'b0);
    n_chk++; if (inst_iq_en !== 4'b0010) begin n_fail++;
      $display("FAIL exc_own_lane: got %b want 0010", inst_iq_en); end
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_room_stall;
    for (int k = 0; k < 13; k++) begin
      drive(4'b1111, 4'b0, 3'd0, 1'b0, 1'b0);
      tick();
    end
    drive(4'b0111, 4'b0, 3'd0, 1'b0, 1'b0);
    tick();
    drive(4'b0111, 4'b0, 3'd2, 1'b0, 1'b0);
    n_chk++; if (rob_room !== 7'd2) begin n_fail++;
      $display("FAIL stall_room: got %0d want 2", rob_room); end
    n_chk++;
    if (wr_pause !== 1'b1 || alloc_fire !== 1'b0 ||
        inst_iq_en !== 4'b0) begin n_fail++;
      $display("FAIL stall_pause: got p=%b f=%b en=%b want 1 0 0000",
               wr_pause, alloc_fire, inst_iq_en); end
    tick();
    drive(4'b0111, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++;
    if (wr_ptr_exp !== 7'h7f || rd_ptr_exp !== 7'h43 ||
        stall_cnt !== 16'd1) begin n_fail++;
      $display("FAIL stall_hold: got wr=%h rd=%h s=%0d want 7f 43 1",
               wr_ptr_exp, rd_ptr_exp, stall_cnt); end
    n_chk++;
    if (rob_room !== 7'd4 || alloc_fire !== 1'b1 ||
        wr_pause !== 1'b0) begin n_fail++;
      $display("FAIL stall_resume: got room=%0d f=%b p=%b want 4 1 0",
               rob_room, alloc_fire, wr_pause); end
    tick();
    drive(4'b0001, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++;
    if (wr_ptr_exp !== 7'h02 || rob_room !== 7'd1 ||
        rob_full !== 1'b0) begin n_fail++;
      $display("FAIL stall_wrapbit: got wr=%h room=%0d f=%b want 02 1 0",
               wr_ptr_exp, rob_room, rob_full); end
    tick();
    drive(4'b0001, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++;
    if (rob_full !== 1'b1 || rob_room !== 7'd0 ||
        wr_pause !== 1'b1) begin n_fail++;
      $display("FAIL full: got f=%b room=%0d p=%b want 1 0 1",
               rob_full, rob_room, wr_pause); end
    tick();
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++; if (stall_cnt !== 16'd2 || wr_ptr_exp !== 7'h03) begin
      n_fail++;
      $display("FAIL full_stall: got s=%0d wr=%h want 2 03",
               stall_cnt, wr_ptr_exp); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 13; k++) begin
      drive(4'b0000, 4'b0, 3'd4, 1'b0, 1'b0);
      tick();
    end
    drive(4'b0000, 4'b0, 3'd2, 1'b0, 1'b0);
    tick();
    drive(4'b1111, 4'b0, 3'd1, 1'b1, 1'b0);
    n_chk++; if (rob_room !== 7'd54) begin n_fail++;
      $display("FAIL flush_occ: got room=%0d want 54", rob_room); end
    n_chk++; if (wr_pause !== 1'b1 || alloc_fire !== 1'b0) begin n_fail++;
      $display("FAIL flush_c0: got p=%b f=%b want 1 0",
               wr_pause, alloc_fire); end
    tick();
    drive(4'b1111, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++;
    if (wr_ptr_exp !== 7'd122 || rd_ptr_exp !== 7'd122 ||
        rob_empty !== 1'b1) begin n_fail++;
      $display("FAIL flush_ptrs: got wr=%0d rd=%0d e=%b want 122 122 1",
               wr_ptr_exp, rd_ptr_exp, rob_empty); end
    n_chk++; if (wr_pause !== 1'b1 || alloc_fire !== 1'b0) begin n_fail++;
      $display("FAIL flush_c1: got p=%b f=%b want 1 0",
               wr_pause, alloc_fire); end
    tick();
    n_chk++; if (wr_pause !== 1'b1 || alloc_fire !== 1'b0) begin n_fail++;
      $display("FAIL flush_c2: got p=%b f=%b want 1 0",
               wr_pause, alloc_fire); end
    tick();
    n_chk++; if (wr_pause !== 1'b0 || alloc_fire !== 1'b1) begin n_fail++;
      $display("FAIL flush_c3: got p=%b f=%b want 0 1",
               wr_pause, alloc_fire); end
    n_chk++; if (stall_cnt !== 16'd5) begin n_fail++;
      $display("FAIL flush_stall: got %0d want 5", stall_cnt); end
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_recover;
    drive(4'b0000, 4'b0, 3'd0, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++; if (wr_pause !== 1'b1) begin n_fail++;
      $display("FAIL rcv_bub2: got %b want 1", wr_pause); end
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (wr_ptr_exp !== 7'd0 || rd_ptr_exp !== 7'd0 ||
        stall_cnt !== 16'd0 || rob_room !== 7'd64) begin n_fail++;
      $display("FAIL rcv_rst: got wr=%0d rd=%0d s=%0d room=%0d",
               wr_ptr_exp, rd_ptr_exp, stall_cnt, rob_room); end
    n_chk++; if (wr_pause !== 1'b0) begin n_fail++;
      $display("FAIL rcv_rst_pause: got %b want 0", wr_pause); end
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b1);
    n_chk++; if (wr_pause !== 1'b1) begin n_fail++;
      $display("FAIL rcv_rst_iq: got %b want 1", wr_pause); end
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++; if (wr_pause !== 1'b0 || rob_empty !== 1'b1) begin n_fail++;
      $display("FAIL rcv_post: got p=%b e=%b want 0 1",
               wr_pause, rob_empty); end
    drive(4'b0011, 4'b0, 3'd0, 1'b0, 1'b1);
    n_chk++; if (wr_pause !== 1'b1 || alloc_fire !== 1'b0) begin n_fail++;
      $display("FAIL rcv_iq_on: got p=%b f=%b want 1 0",
               wr_pause, alloc_fire); end
    tick();
    drive(4'b0000, 4'b0, 3'd0, 1'b0, 1'b0);
    n_chk++; if (stall_cnt !== 16'd1 || wr_ptr_exp !== 7'd0) begin
      n_fail++;
      $display("FAIL rcv_iq_stall: got s=%0d wr=%0d want 1 0",
               stall_cnt, wr_ptr_exp); end
    tick();
    n_chk++; if (wr_pause !== 1'b0) begin n_fail++;
      $display("FAIL rcv_iq_off: got %b want 0", wr_pause); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_except_mask();
    test_room_stall();
    test_flush();
    test_reset_recover();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
